jk_bank_arbiter: RTL



---
 rtl/jk_pkg.sv | 18 +
 rtl/jk_arb_pick.sv | 32 +++
 rtl/jk_bank_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank arbiter: op codes, FSM states and requester ids.
package jk_pkg;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_RESET  = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_ACK   = 2'd2
   } arb_state_e;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/jk_arb_pick.sv
// Combinational winner selection between requesters A and B.
// JK_BANK_ARBITER_RR_EN selects round-robin on contention; otherwise A has fixed priority.
module jk_arb_pick
   import jk_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last_grant,
   output logic valid,
   output logic winner
);

`ifndef JK_BANK_ARBITER_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      valid  = req_a | req_b;
      winner = REQ_A;
      if (req_a && req_b) begin
`ifdef JK_BANK_ARBITER_RR_EN
         winner = ~last_grant;
`else
         winner = REQ_A;
`endif
      end else if (req_b) begin
         winner = REQ_B;
      end
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Two-requester 4-phase handshake arbiter driving a shared JK flip-flop bank for one edge.
// Arbitration policy set by JK_BANK_ARBITER_RR_EN (see jk_arb_pick).
module jk_bank_arbiter
   import jk_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         req_a,
   input  logic [1:0]   op_a,
   input  logic [N-1:0] mask_a,
   output logic         ack_a,
   input  logic         req_b,
   input  logic [1:0]   op_b,
   input  logic [N-1:0] mask_b,
   output logic         ack_b,
   output logic [N-1:0] j,
   output logic [N-1:0] k,
   output logic         busy,
   output logic         last_grant
);

   arb_state_e   state;
   logic         pick_valid;
   logic         pick;
   logic [1:0]   sel_op;
   logic [N-1:0] sel_mask;
   logic         served_req;

   jk_arb_pick u_pick (
      .req_a      (req_a),
      .req_b      (req_b),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .winner     (pick)
   );

   always_comb begin
      sel_op     = (pick == REQ_B) ? op_b : op_a;
      sel_mask   = (pick == REQ_B) ? mask_b : mask_a;
      served_req = (last_grant == REQ_B) ? req_b : req_a;
   end

   assign busy = (state != S_IDLE);

   // j/k registers double as the command latch: loaded at grant, shown for the APPLY cycle only.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state      <= S_IDLE;
         j          <= '0;
         k          <= '0;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         last_grant <= REQ_B;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  last_grant <= pick;
                  j          <= sel_mask & {N{sel_op[1]}};
                  k          <= sel_mask & {N{sel_op[0]}};
                  state      <= S_APPLY;
               end
            end
            S_APPLY: begin
               j     <= '0;
               k     <= '0;
               ack_a <= (last_grant == REQ_A);
               ack_b <= (last_grant == REQ_B);
               state <= S_ACK;
            end
            S_ACK: begin
               if (!served_req) begin
                  ack_a <= 1'b0;
                  ack_b <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
